fetch_stage: RTL and testbench

- Instruction-fetch stage of the 64-bit in-order pipeline, between the PC register and the F/D pipeline register.
- Issues one instruction-memory request per PC and waits for a variable-latency response.
- Computes the predicted next PC (fetch_o_pre_pc) that the PC register loads, and raises a stall request until the fetch completes.
- Discards stale responses after an execute-stage redirect.

---
 rtl/fetch_stage.sv | 170 +++++++++++++++++
 tb/tb_fetch_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: one outstanding imem request per PC, variable
// response latency, skid buffer for decode back-pressure and a drain path
// that discards the stale response after an execute redirect.
// Optional feature macro: STATIC_JAL_PREDICT_EN (static JAL target prediction).
module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc,
  input  logic        execute_i_need_jump,
  input  logic        decode_i_stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [63:0] fetch_o_pre_pc,
  output logic        fetch_o_stall_req,
  output logic        fetch_o_valid,
  output logic [63:0] fetch_o_pc,
  output logic [31:0] fetch_o_instr,
  output logic        fetch_o_pred_taken
);

  localparam int unsigned XLEN   = 64;
  localparam int unsigned ILEN   = 32;
  localparam int unsigned OPC_W  = 7;
  localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);
`ifdef STATIC_JAL_PREDICT_EN
  localparam logic [OPC_W-1:0] OPC_JAL = OPC_W'(7'b1101111);
`endif

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [ILEN-1:0] skid_q;
  logic            skid_load;
  logic            complete;
  logic [ILEN-1:0] cmp_word;
  logic            pred_jal;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, request and completion decode
  always_comb begin
    state_d        = state_q;
    imem_req_valid = 1'b0;
    complete       = 1'b0;
    skid_load      = 1'b0;
    cmp_word       = imem_resp_data;
    case (state_q)
      S_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) begin
          state_d = execute_i_need_jump ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (execute_i_need_jump) begin
            state_d = S_REQ;
          end else if (!decode_i_stall) begin
            complete = 1'b1;
            state_d  = S_REQ;
          end else begin
            skid_load = 1'b1;
            state_d   = S_HOLD;
          end
        end else if (execute_i_need_jump) begin
          state_d = S_DRAIN;
        end
      end
      S_HOLD: begin
        cmp_word = skid_q;
        if (execute_i_need_jump) begin
          state_d = S_REQ;
        end else if (!decode_i_stall) begin
          complete = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_resp_valid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // Skid register holds a response that decode could not take yet
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_q <= ILEN'(0);
    end else if (skid_load) begin
      skid_q <= imem_resp_data;
    end
  end

  assign imem_req_addr     = pc;
  assign fetch_o_stall_req = !complete && !execute_i_need_jump;

`ifdef STATIC_JAL_PREDICT_EN
  logic [XLEN-1:0] jal_imm;

  // Static JAL prediction: target = pc + sign-extended J-immediate
  always_comb begin
    pred_jal = (cmp_word[OPC_W-1:0] == OPC_JAL);
    jal_imm  = {{(XLEN-21){cmp_word[31]}}, cmp_word[31], cmp_word[19:12],
                cmp_word[20], cmp_word[30:21], 1'b0};
    if (complete && pred_jal) begin
      fetch_o_pre_pc = pc + jal_imm;
    end else begin
      fetch_o_pre_pc = pc + INSTR_BYTES;
    end
  end

  // Prediction flag travels with the instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_o_pred_taken <= 1'b0;
    end else if (execute_i_need_jump) begin
      fetch_o_pred_taken <= 1'b0;
    end else if (complete) begin
      fetch_o_pred_taken <= pred_jal;
    end else if (!decode_i_stall) begin
      fetch_o_pred_taken <= 1'b0;
    end
  end
`else
  assign pred_jal           = 1'b0;
  assign fetch_o_pre_pc     = pc + INSTR_BYTES;
  assign fetch_o_pred_taken = 1'b0;
`endif

  // F/D output register: flush, load, hold, bubble in priority order
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_o_valid <= 1'b0;
      fetch_o_pc    <= RESET_PC;
      fetch_o_instr <= NOP_INSTR;
    end else if (execute_i_need_jump) begin
      fetch_o_valid <= 1'b0;
      fetch_o_instr <= NOP_INSTR;
    end else if (complete) begin
      fetch_o_valid <= 1'b1;
      fetch_o_pc    <= pc;
      fetch_o_instr <= cmp_word;
    end else if (!decode_i_stall) begin
      fetch_o_valid <= 1'b0;
      fetch_o_instr <= NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then
// randomized traffic against a transaction-level model plus PC register and
// variable-latency memory models.
module tb_fetch_stage;

  localparam logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc;
  logic        execute_i_need_jump;
  logic        decode_i_stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [63:0] fetch_o_pre_pc;
  logic        fetch_o_stall_req;
  logic        fetch_o_valid;
  logic [63:0] fetch_o_pc;
  logic [31:0] fetch_o_instr;
  logic        fetch_o_pred_taken;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst), .pc(pc),
    .execute_i_need_jump(execute_i_need_jump), .decode_i_stall(decode_i_stall),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .fetch_o_pre_pc(fetch_o_pre_pc),
    .fetch_o_stall_req(fetch_o_stall_req), .fetch_o_valid(fetch_o_valid),
    .fetch_o_pc(fetch_o_pc), .fetch_o_instr(fetch_o_instr),
    .fetch_o_pred_taken(fetch_o_pred_taken)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: request in flight, whether it is stale, and a word held for decode
  bit          m_out, m_stale, m_held;
  logic [31:0] m_held_word;
  logic        e_valid, e_pred;
  logic [63:0] e_pc;
  logic [31:0] e_instr;
  logic [63:0] pc_reg, jt;
  bit          g_hs;

  // Samples of the last cycle, for literal checks
  logic        s_req_valid, s_stall, s_valid, s_pred;
  logic [63:0] s_req_addr, s_pre_pc, s_opc;
  logic [31:0] s_instr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Address the PC register moves to after fetching word w at address a
  function automatic logic [63:0] predicted(input logic [63:0] a, input logic [31:0] w);
    longint off;
    off = 4;
`ifdef STATIC_JAL_PREDICT_EN
    if (w[6:0] == 7'h6F) begin
      logic signed [20:0] j;
      j = {w[31], w[19:12], w[20], w[30:21], 1'b0};
      off = longint'(j);
    end
`endif
    return a + 64'(off);
  endfunction

  function automatic logic is_jal(input logic [31:0] w);
`ifdef STATIC_JAL_PREDICT_EN
    return w[6:0] == 7'h6F;
`else
    return 1'b0;
`endif
  endfunction

  // One clock: drive, predict, compare, then advance model and PC register
  task automatic cycle(input logic jump, input logic dstall, input logic ready,
                       input logic resp, input logic [31:0] data);
    logic        from_resp, word_ok, done, e_req, e_stall;
    logic [31:0] word;
    logic [63:0] e_pre;
    @(negedge clk);
    pc                  = pc_reg;
    execute_i_need_jump = jump;
    decode_i_stall      = dstall;
    imem_req_ready      = ready;
    imem_resp_valid     = resp;
    imem_resp_data      = data;
    #1;
    from_resp = m_out && !m_stale && resp;
    word_ok   = from_resp || m_held;
    word      = from_resp ? data : m_held_word;
    done      = word_ok && !jump && !dstall;
    e_req     = !m_out && !m_held;
    e_stall   = !done && !jump;
    e_pre     = predicted(pc_reg, word);
    g_hs      = e_req && ready;

    s_req_valid = imem_req_valid; s_req_addr = imem_req_addr;
    s_stall = fetch_o_stall_req;  s_pre_pc = fetch_o_pre_pc;
    s_valid = fetch_o_valid; s_opc = fetch_o_pc;
    s_instr = fetch_o_instr; s_pred = fetch_o_pred_taken;

    chk("req_valid", imem_req_valid, e_req);
    if (e_req) chk("req_addr", imem_req_addr, pc_reg);
    chk("stall_req", fetch_o_stall_req, e_stall);
    if (done) chk("pre_pc", fetch_o_pre_pc, e_pre);
    chk("valid", fetch_o_valid, e_valid);
    chk("instr", fetch_o_instr, e_instr);
    if (e_valid) begin
      chk("out_pc", fetch_o_pc, e_pc);
      chk("pred_taken", fetch_o_pred_taken, e_pred);
    end

    @(posedge clk);
    if (jump) begin
      e_valid = 0; e_instr = NOP_INSTR; e_pred = 0;
    end else if (done) begin
      e_valid = 1; e_pc = pc_reg; e_instr = word; e_pred = is_jal(word);
    end else if (!dstall) begin
      e_valid = 0; e_instr = NOP_INSTR; e_pred = 0;
    end
    if (!e_stall) pc_reg = jump ? jt : e_pre;
    if (m_out && resp) begin
      m_out = 0;
      if (!m_stale && !jump && dstall) begin
        m_held = 1; m_held_word = data;
      end
      m_stale = 0;
    end else if (m_out && jump) begin
      m_stale = 1;
    end else if (m_held && (jump || !dstall)) begin
      m_held = 0;
    end
    if (g_hs) begin
      m_out = 1; m_stale = jump;
    end
  endtask

  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_word;

  initial begin
    rst = 1; pc = RESET_PC; execute_i_need_jump = 0; decode_i_stall = 0;
    imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0;
    m_out = 0; m_stale = 0; m_held = 0; m_held_word = 0;
    e_valid = 0; e_pc = RESET_PC; e_instr = NOP_INSTR; e_pred = 0;
    pc_reg = RESET_PC; jt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", fetch_o_valid, 1'b0);
    chk("rst_pc", fetch_o_pc, RESET_PC);
    chk("rst_instr", fetch_o_instr, NOP_INSTR);
    chk("rst_pred", fetch_o_pred_taken, 1'b0);
    rst = 0;

    // Basic fetch with 1-cycle response
    cycle(0, 0, 1, 0, 32'h0);
    chk("c1_req_valid", s_req_valid, 1'b1);
    chk("c1_req_addr", s_req_addr, 64'h8000_0000);
    cycle(0, 0, 1, 1, 32'h0050_0093);
    chk("c2_stall", s_stall, 1'b0);
    chk("c2_pre_pc", s_pre_pc, 64'h8000_0004);
    cycle(0, 0, 1, 0, 32'h0);
    chk("c3_valid", s_valid, 1'b1);
    chk("c3_pc", s_opc, 64'h8000_0000);
    chk("c3_instr", s_instr, 32'h0050_0093);
    chk("c3_req_addr", s_req_addr, 64'h8000_0004);

    // Long response latency: stall held, no second request, bubble out
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 1, 0, 32'h0);
      chk("wait_stall", s_stall, 1'b1);
      chk("wait_no_req", s_req_valid, 1'b0);
    end
    chk("wait_bubble", s_valid, 1'b0);
    cycle(0, 0, 1, 1, 32'h00A0_0113);
    chk("c9_pre_pc", s_pre_pc, 64'h8000_0008);
    cycle(0, 0, 1, 0, 32'h0);
    chk("c10_pc", s_opc, 64'h8000_0004);

    // Redirect while waiting; stale response must be dropped
    jt = 64'h8000_1000;
    cycle(1, 0, 1, 0, 32'h0);
    chk("jump_stall", s_stall, 1'b0);
    cycle(0, 0, 1, 0, 32'h0);
    cycle(0, 0, 1, 1, 32'hDEAD_BEEF);
    chk("drain_stall", s_stall, 1'b1);
    cycle(0, 0, 1, 0, 32'h0);
    chk("redir_addr", s_req_addr, 64'h8000_1000);
    chk("no_stale", s_valid, 1'b0);

    // Decode back-pressure: word parks in skid, released later
    cycle(0, 1, 1, 1, 32'h0000_0513);
    cycle(0, 1, 1, 0, 32'h0);
    chk("hold_stall", s_stall, 1'b1);
    chk("hold_valid", s_valid, 1'b0);
    cycle(0, 0, 1, 0, 32'h0);
    chk("skid_stall", s_stall, 1'b0);
    chk("skid_pre_pc", s_pre_pc, 64'h8000_1004);
    jt = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle(1, 0, 0, 0, 32'h0);
    chk("skid_valid", s_valid, 1'b1);
    chk("skid_instr", s_instr, 32'h0000_0513);
    chk("skid_pc", s_opc, 64'h8000_1000);
    chk("skid_adv", s_req_addr, 64'h8000_1004);

    // PC wrap at the top of the address space
    cycle(0, 0, 1, 0, 32'h0);
    chk("wrap_addr", s_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(0, 0, 1, 1, 32'h0000_0013);
    chk("wrap_pre_pc", s_pre_pc, 64'h0);
    jt = 64'h8000_0000;
    cycle(1, 0, 0, 0, 32'h0);
    chk("wrap_req_addr", s_req_addr, 64'h0);

    // JAL at 0x80000000
    cycle(0, 0, 1, 0, 32'h0);
    cycle(0, 0, 1, 1, 32'h0100_006F);
`ifdef STATIC_JAL_PREDICT_EN
    chk("jal_pre_pc", s_pre_pc, 64'h8000_0010);
`else
    chk("jal_pre_pc", s_pre_pc, 64'h8000_0004);
`endif
    cycle(0, 0, 0, 0, 32'h0);
`ifdef STATIC_JAL_PREDICT_EN
    chk("jal_pred", s_pred, 1'b1);
`else
    chk("jal_pred", s_pred, 1'b0);
`endif

    // Randomized traffic against the variable-latency memory model
    mem_busy = 0; mem_cnt = 0; mem_word = 0;
    for (int n = 0; n < 4000; n++) begin
      logic        r_jump, r_dstall, r_ready, r_resp;
      logic [31:0] r_data;
      r_data = $urandom;
      r_resp = 0;
      if (mem_busy && mem_cnt == 0) begin
        r_resp = 1; r_data = mem_word;
      end else if (!mem_busy && !m_out && !m_held && $urandom_range(0, 15) == 0) begin
        r_resp = 1;
      end
      r_jump   = ($urandom_range(0, 11) == 0);
      r_dstall = ($urandom_range(0, 3) == 0);
      r_ready  = ($urandom_range(0, 3) != 0);
      if (r_jump) jt = {$urandom, $urandom & 32'hFFFF_FFFC};
      cycle(r_jump, r_dstall, r_ready, r_resp, r_data);
      if (mem_busy) begin
        if (r_resp) mem_busy = 0;
        else mem_cnt--;
      end
      if (g_hs) begin
        mem_busy = 1;
        mem_cnt  = $urandom_range(0, 4);
        mem_word = $urandom;
        if ($urandom_range(0, 3) == 0) mem_word[6:0] = 7'h6F;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
